// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding, flag bundle and overflow helper for alu_seq_muldiv.
// Optional mul/div hardware is selected by the ALU_MULDIV_EN macro.
package alu_pkg;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4;
  localparam logic [4:0] OP_SRA = 5'd5;
  localparam logic [4:0] OP_MUL = 5'd6;
  localparam logic [4:0] OP_DIV = 5'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic ne;
    logic lt;
    logic exc;
  } alu_flags_t;

  // Subtraction adds ~B, so B's effective sign is inverted before the same-sign test.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic r_msb, input logic is_sub);
    logic b_eff;
    b_eff = b_msb ^ is_sub;
    return (a_msb == b_eff) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// WIDTH-step iterative signed multiply (radix-2 shift-add) and restoring divide.
// Only instantiated when ALU_MULDIV_EN is defined.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             exc_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             busy_q, is_div_q, neg_q, dz_q, dovf_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d, opd_q;
  logic [WIDTH:0]   r_sh, diff, addend, sum, upper;
  logic [WIDTH-1:0] a_mag, b_mag, quo;
  logic             last;

  assign a_mag  = a_i[WIDTH-1] ? -a_i : a_i;
  assign b_mag  = b_i[WIDTH-1] ? -b_i : b_i;
  assign last   = busy_q && (cnt_q == CW'(WIDTH-1));
  assign done_o = last;

  // hi:lo is {accumulator, multiplier} for mul and {remainder, dividend/quotient} for div.
  always_comb begin
    r_sh   = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    diff   = r_sh - {1'b0, opd_q};
    addend = '0;
    if (lo_q[0]) addend = last ? -{opd_q[WIDTH-1], opd_q} : {opd_q[WIDTH-1], opd_q};
    sum    = hi_q + addend;
    if (is_div_q) begin
      hi_d = diff[WIDTH] ? {1'b0, r_sh[WIDTH-1:0]} : {1'b0, diff[WIDTH-1:0]};
      lo_d = {lo_q[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      hi_d = {sum[WIDTH], sum[WIDTH:1]};
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Result is taken from the final step's next-state so it lands on the same edge.
  always_comb begin
    quo   = neg_q ? -lo_d : lo_d;
    upper = {hi_d[WIDTH-1:0], lo_d[WIDTH-1]};
    if (is_div_q) begin
      result_o = dz_q ? '0 : quo;
      exc_o    = dz_q | dovf_q;
    end else begin
      result_o = lo_d;
      exc_o    = !((&upper) || !(|upper));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      dovf_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opd_q    <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      is_div_q <= is_div_i;
      neg_q    <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
      dz_q     <= (b_i == '0);
      dovf_q   <= (a_i == MIN_NEG) && (&b_i);
      hi_q     <= '0;
      lo_q     <= is_div_i ? a_mag : b_i;
      opd_q    <= is_div_i ? b_mag : a_i;
    end else if (busy_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= last ? '0 : cnt_q + CW'(1);
      if (last) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq_muldiv.sv
// Registered execute-stage ALU with valid/ready handshake; multi-cycle mul/div
// are present only when ALU_MULDIV_EN is defined, otherwise opcodes 6/7 are illegal.
module alu_seq_muldiv
  import alu_pkg::*;
#(
  parameter int  WIDTH      = 32,
  parameter bit  SIGNED_CMP = 1'b1,
  localparam int SHAMT_W    = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         ctrl_ALUopcode,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [WIDTH-1:0]   data_operandB,
  output logic               out_valid,
  output logic [WIDTH-1:0]   data_result,
  output logic               isNotEqual,
  output logic               isLessThan,
  output logic               data_exception
);

  logic             accept, is_md;
  logic [WIDTH-1:0] add_r, sc_res;
  logic [WIDTH:0]   sub_w;
  logic             add_ovf, sub_ovf, lt, ne, sc_exc;
  logic             vld_q;
  logic [WIDTH-1:0] res_q;
  alu_flags_t       flg_q;

  assign accept  = in_valid && in_ready;
  assign add_r   = data_operandA + data_operandB;
  assign sub_w   = {1'b0, data_operandA} - {1'b0, data_operandB};
  assign add_ovf = signed_ovf(data_operandA[WIDTH-1], data_operandB[WIDTH-1], add_r[WIDTH-1], 1'b0);
  assign sub_ovf = signed_ovf(data_operandA[WIDTH-1], data_operandB[WIDTH-1], sub_w[WIDTH-1], 1'b1);
  assign lt      = SIGNED_CMP ? (sub_w[WIDTH-1] ^ sub_ovf) : sub_w[WIDTH];
  assign ne      = (data_operandA != data_operandB);

  always_comb begin
    sc_res = '0;
    sc_exc = 1'b0;
    case (ctrl_ALUopcode)
      OP_ADD: begin sc_res = add_r; sc_exc = add_ovf; end
      OP_SUB: begin sc_res = sub_w[WIDTH-1:0]; sc_exc = sub_ovf; end
      OP_AND: sc_res = data_operandA & data_operandB;
      OP_OR:  sc_res = data_operandA | data_operandB;
      OP_SLL: sc_res = data_operandA << ctrl_shiftamt;
      OP_SRA: sc_res = $signed(data_operandA) >>> ctrl_shiftamt;
      default: sc_exc = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  state_e           state_q;
  logic [1:0]       pend_q;
  logic             md_done, md_exc;
  logic [WIDTH-1:0] md_res;

  assign is_md    = (ctrl_ALUopcode == OP_MUL) || (ctrl_ALUopcode == OP_DIV);
  assign in_ready = (state_q == ST_IDLE);

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clock    (clock),
    .reset_n  (reset_n),
    .start_i  (accept && is_md),
    .is_div_i (ctrl_ALUopcode == OP_DIV),
    .a_i      (data_operandA),
    .b_i      (data_operandB),
    .done_o   (md_done),
    .result_o (md_res),
    .exc_o    (md_exc)
  );
`else
  assign is_md    = 1'b0;
  assign in_ready = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= 1'b0;
      res_q <= '0;
      flg_q <= '0;
`ifdef ALU_MULDIV_EN
      state_q <= ST_IDLE;
      pend_q  <= '0;
`endif
    end else begin
      vld_q <= 1'b0;
      if (accept && !is_md) begin
        vld_q <= 1'b1;
        res_q <= sc_res;
        flg_q <= {ne, lt, sc_exc};
      end
`ifdef ALU_MULDIV_EN
      // Compare flags are frozen at accept since operands are don't-care once busy.
      case (state_q)
        ST_IDLE: if (accept && is_md) begin
          state_q <= ST_BUSY;
          pend_q  <= {ne, lt};
        end
        ST_BUSY: if (md_done) begin
          state_q <= ST_IDLE;
          vld_q   <= 1'b1;
          res_q   <= md_res;
          flg_q   <= {pend_q, md_exc};
        end
        default: state_q <= ST_IDLE;
      endcase
`endif
    end
  end

  assign out_valid      = vld_q;
  assign data_result    = res_q;
  assign isNotEqual     = flg_q.ne;
  assign isLessThan     = flg_q.lt;
  assign data_exception = flg_q.exc;

endmodule
